// File: rtl/axi_jtag_core_arbiter.sv
// 2:1 AXI4 arbiter: CPU core (s0) and JTAG loader (s1) onto one memory port.
// Read and write paths each own a grant register and a single-outstanding FSM.
module axi_jtag_core_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   s0_axi_arid,
  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic [7:0]        s0_axi_arlen,
  input  logic [2:0]        s0_axi_arsize,
  input  logic [1:0]        s0_axi_arburst,
  input  logic              s0_axi_arlock,
  input  logic [3:0]        s0_axi_arcache,
  input  logic [2:0]        s0_axi_arprot,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [ID_W-1:0]   s0_axi_rid,
  output logic [DATA_W-1:0] s0_axi_rdata,
  output logic [1:0]        s0_axi_rresp,
  output logic              s0_axi_rlast,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,
  input  logic [ID_W-1:0]   s0_axi_awid,
  input  logic [ADDR_W-1:0] s0_axi_awaddr,
  input  logic [7:0]        s0_axi_awlen,
  input  logic [2:0]        s0_axi_awsize,
  input  logic [1:0]        s0_axi_awburst,
  input  logic              s0_axi_awlock,
  input  logic [3:0]        s0_axi_awcache,
  input  logic [2:0]        s0_axi_awprot,
  input  logic              s0_axi_awvalid,
  output logic              s0_axi_awready,
  input  logic [DATA_W-1:0] s0_axi_wdata,
  input  logic [DATA_W/8-1:0] s0_axi_wstrb,
  input  logic              s0_axi_wlast,
  input  logic              s0_axi_wvalid,
  output logic              s0_axi_wready,
  output logic [ID_W-1:0]   s0_axi_bid,
  output logic [1:0]        s0_axi_bresp,
  output logic              s0_axi_bvalid,
  input  logic              s0_axi_bready,
  input  logic [ID_W-1:0]   s1_axi_arid,
  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic [7:0]        s1_axi_arlen,
  input  logic [2:0]        s1_axi_arsize,
  input  logic [1:0]        s1_axi_arburst,
  input  logic              s1_axi_arlock,
  input  logic [3:0]        s1_axi_arcache,
  input  logic [2:0]        s1_axi_arprot,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [ID_W-1:0]   s1_axi_rid,
  output logic [DATA_W-1:0] s1_axi_rdata,
  output logic [1:0]        s1_axi_rresp,
  output logic              s1_axi_rlast,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,
  input  logic [ID_W-1:0]   s1_axi_awid,
  input  logic [ADDR_W-1:0] s1_axi_awaddr,
  input  logic [7:0]        s1_axi_awlen,
  input  logic [2:0]        s1_axi_awsize,
  input  logic [1:0]        s1_axi_awburst,
  input  logic              s1_axi_awlock,
  input  logic [3:0]        s1_axi_awcache,
  input  logic [2:0]        s1_axi_awprot,
  input  logic              s1_axi_awvalid,
  output logic              s1_axi_awready,
  input  logic [DATA_W-1:0] s1_axi_wdata,
  input  logic [DATA_W/8-1:0] s1_axi_wstrb,
  input  logic              s1_axi_wlast,
  input  logic              s1_axi_wvalid,
  output logic              s1_axi_wready,
  output logic [ID_W-1:0]   s1_axi_bid,
  output logic [1:0]        s1_axi_bresp,
  output logic              s1_axi_bvalid,
  input  logic              s1_axi_bready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              rd_owner,
  output logic              wr_owner
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_st_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_st_e;

  rd_st_e rd_st_q, rd_st_d;
  wr_st_e wr_st_q, wr_st_d;
  logic   rd_gnt_q, rd_gnt_d;
  logic   wr_gnt_q, wr_gnt_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic rd_a, rd_r, wr_x, wr_b;
  logic aw_hs, wl_hs;

  assign rd_a = (rd_st_q == R_ADDR);
  assign rd_r = (rd_st_q == R_DATA);
  assign wr_x = (wr_st_q == W_XFER);
  assign wr_b = (wr_st_q == W_RESP);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_st_q   <= R_IDLE;
      wr_st_q   <= W_IDLE;
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rd_st_q   <= rd_st_d;
      wr_st_q   <= wr_st_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_gnt_q  <= wr_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Fixed priority: JTAG wins ties; grant only moves in IDLE.
  always_comb begin
    rd_st_d  = rd_st_q;
    rd_gnt_d = rd_gnt_q;
    case (rd_st_q)
      R_IDLE: if (s0_axi_arvalid | s1_axi_arvalid) begin
        rd_gnt_d = s1_axi_arvalid;
        rd_st_d  = R_ADDR;
      end
      R_ADDR: if (m_axi_arvalid & m_axi_arready) rd_st_d = R_DATA;
      R_DATA: if (m_axi_rvalid & m_axi_rready & m_axi_rlast)
        rd_st_d = R_IDLE;
      default: rd_st_d = R_IDLE;
    endcase
  end

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign wl_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_gnt_d  = wr_gnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wr_st_q)
      W_IDLE: if (s0_axi_awvalid | s0_axi_wvalid |
                  s1_axi_awvalid | s1_axi_wvalid) begin
        wr_gnt_d = s1_axi_awvalid | s1_axi_wvalid;
        wr_st_d  = W_XFER;
      end
      W_XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | wl_hs;
        if (aw_done_d & w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wr_st_d   = W_RESP;
        end
      end
      W_RESP: if (m_axi_bvalid & m_axi_bready) wr_st_d = W_IDLE;
      default: wr_st_d = W_IDLE;
    endcase
  end

  assign rd_owner = rd_gnt_q;
  assign wr_owner = wr_gnt_q;

  assign m_axi_arid    = rd_gnt_q ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr  = rd_gnt_q ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen   = rd_gnt_q ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize  = rd_gnt_q ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst = rd_gnt_q ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock  = rd_gnt_q ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache = rd_gnt_q ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot  = rd_gnt_q ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arvalid = rd_a &
    (rd_gnt_q ? s1_axi_arvalid : s0_axi_arvalid);
  assign s0_axi_arready = rd_a & ~rd_gnt_q & m_axi_arready;
  assign s1_axi_arready = rd_a &  rd_gnt_q & m_axi_arready;

  assign s0_axi_rid    = m_axi_rid;
  assign s0_axi_rdata  = m_axi_rdata;
  assign s0_axi_rresp  = m_axi_rresp;
  assign s0_axi_rlast  = m_axi_rlast;
  assign s1_axi_rid    = m_axi_rid;
  assign s1_axi_rdata  = m_axi_rdata;
  assign s1_axi_rresp  = m_axi_rresp;
  assign s1_axi_rlast  = m_axi_rlast;
  assign s0_axi_rvalid = rd_r & ~rd_gnt_q & m_axi_rvalid;
  assign s1_axi_rvalid = rd_r &  rd_gnt_q & m_axi_rvalid;
  assign m_axi_rready  = rd_r &
    (rd_gnt_q ? s1_axi_rready : s0_axi_rready);

  assign m_axi_awid    = wr_gnt_q ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr  = wr_gnt_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen   = wr_gnt_q ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize  = wr_gnt_q ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst = wr_gnt_q ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock  = wr_gnt_q ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache = wr_gnt_q ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot  = wr_gnt_q ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awvalid = wr_x & ~aw_done_q &
    (wr_gnt_q ? s1_axi_awvalid : s0_axi_awvalid);
  assign s0_axi_awready = wr_x & ~aw_done_q & ~wr_gnt_q & m_axi_awready;
  assign s1_axi_awready = wr_x & ~aw_done_q &  wr_gnt_q & m_axi_awready;

  assign m_axi_wdata  = wr_gnt_q ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb  = wr_gnt_q ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast  = wr_gnt_q ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid = wr_x & ~w_done_q &
    (wr_gnt_q ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready = wr_x & ~w_done_q & ~wr_gnt_q & m_axi_wready;
  assign s1_axi_wready = wr_x & ~w_done_q &  wr_gnt_q & m_axi_wready;

  assign s0_axi_bid    = m_axi_bid;
  assign s0_axi_bresp  = m_axi_bresp;
  assign s1_axi_bid    = m_axi_bid;
  assign s1_axi_bresp  = m_axi_bresp;
  assign s0_axi_bvalid = wr_b & ~wr_gnt_q & m_axi_bvalid;
  assign s1_axi_bvalid = wr_b &  wr_gnt_q & m_axi_bvalid;
  assign m_axi_bready  = wr_b &
    (wr_gnt_q ? s1_axi_bready : s0_axi_bready);

endmodule

// File: tb/tb_axi_jtag_core_arbiter.sv
// Bench for axi_jtag_core_arbiter: two master agents, a memory-like slave
// and transaction-level expectations.
module tb_axi_jtag_core_arbiter;

  logic aclk;
  logic aresetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [3:0]  arid[2];
  logic [31:0] araddr[2];
  logic [7:0]  arlen[2];
  logic        arvalid[2];
  logic        arready[2];
  logic [3:0]  rid[2];
  logic [31:0] rdata[2];
  logic [1:0]  rresp[2];
  logic        rlast[2];
  logic        rvalid[2];
  logic        rready[2];
  logic [3:0]  awid[2];
  logic [31:0] awaddr[2];
  logic [7:0]  awlen[2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata[2];
  logic        wlast[2];
  logic        wvalid[2];
  logic        wready[2];
  logic [3:0]  bid[2];
  logic [1:0]  bresp[2];
  logic        bvalid[2];
  logic        bready[2];

  logic [3:0]  m_arid, m_awid, m_rid, m_bid, m_arcache, m_awcache;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arlock, m_awlock;
  logic [3:0]  m_wstrb;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;
  logic        rd_owner, wr_owner;

  logic [31:0] sw_aw[$];
  logic [31:0] sw_w[$];
  logic [3:0]  sw_id;
  int          ar_order[$];
  int          ar_cyc[2];
  int          last_cyc[2];
  int          beats_seen[2];

  axi_jtag_core_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_arid(arid[0]), .s0_axi_araddr(araddr[0]),
    .s0_axi_arlen(arlen[0]), .s0_axi_arsize(3'd2),
    .s0_axi_arburst(2'b01), .s0_axi_arlock(1'b0),
    .s0_axi_arcache(4'd0), .s0_axi_arprot(3'd0),
    .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]),
    .s0_axi_rid(rid[0]), .s0_axi_rdata(rdata[0]),
    .s0_axi_rresp(rresp[0]), .s0_axi_rlast(rlast[0]),
    .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
    .s0_axi_awid(awid[0]), .s0_axi_awaddr(awaddr[0]),
    .s0_axi_awlen(awlen[0]), .s0_axi_awsize(3'd2),
    .s0_axi_awburst(2'b01), .s0_axi_awlock(1'b0),
    .s0_axi_awcache(4'd0), .s0_axi_awprot(3'd0),
    .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
    .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(4'hF),
    .s0_axi_wlast(wlast[0]), .s0_axi_wvalid(wvalid[0]),
    .s0_axi_wready(wready[0]),
    .s0_axi_bid(bid[0]), .s0_axi_bresp(bresp[0]),
    .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
    .s1_axi_arid(arid[1]), .s1_axi_araddr(araddr[1]),
    .s1_axi_arlen(arlen[1]), .s1_axi_arsize(3'd2),
    .s1_axi_arburst(2'b01), .s1_axi_arlock(1'b0),
    .s1_axi_arcache(4'd0), .s1_axi_arprot(3'd2),
    .s1_axi_arvalid(arvalid[1]), .s1_axi_arready(arready[1]),
    .s1_axi_rid(rid[1]), .s1_axi_rdata(rdata[1]),
    .s1_axi_rresp(rresp[1]), .s1_axi_rlast(rlast[1]),
    .s1_axi_rvalid(rvalid[1]), .s1_axi_rready(rready[1]),
    .s1_axi_awid(awid[1]), .s1_axi_awaddr(awaddr[1]),
    .s1_axi_awlen(awlen[1]), .s1_axi_awsize(3'd2),
    .s1_axi_awburst(2'b01), .s1_axi_awlock(1'b0),
    .s1_axi_awcache(4'd0), .s1_axi_awprot(3'd2),
    .s1_axi_awvalid(awvalid[1]), .s1_axi_awready(awready[1]),
    .s1_axi_wdata(wdata[1]), .s1_axi_wstrb(4'hF),
    .s1_axi_wlast(wlast[1]), .s1_axi_wvalid(wvalid[1]),
    .s1_axi_wready(wready[1]),
    .s1_axi_bid(bid[1]), .s1_axi_bresp(bresp[1]),
    .s1_axi_bvalid(bvalid[1]), .s1_axi_bready(bready[1]),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr),
    .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
    .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
    .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
    .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr),
    .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
    .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid),
    .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .rd_owner(rd_owner), .wr_owner(wr_owner)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One tick before the rising edge: every tb driver is settled by then.
  task automatic pre_edge();
    @(negedge aclk);
    #4;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Memory contents seen by the reference: a fixed hash of the address.
  function automatic logic [31:0] memv(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [2:0] prot_of(input int n);
    return (n == 1) ? 3'd2 : 3'd0;
  endfunction

  task automatic slv_rd();
    logic [31:0] a;
    logic [7:0]  l;
    logic [3:0]  id;
    bit          hs;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_arready = 1'b1;
    hs = 1'b0;
    while (!hs) begin
      pre_edge();
      hs = aresetn & m_arvalid;
      a  = m_araddr;
      l  = m_arlen;
      id = m_arid;
      step();
    end
    m_arready = 1'b0;
    for (int b = 0; b <= int'(l); b++) begin
      m_rvalid = 1'b1;
      m_rid    = id;
      m_rresp  = 2'b00;
      m_rdata  = memv(a + 32'(4 * b));
      m_rlast  = (b == int'(l));
      hs = 1'b0;
      while (!hs) begin
        pre_edge();
        if (!aresetn) begin
          m_rvalid = 1'b0;
          return;
        end
        hs = m_rready;
        step();
      end
      m_rvalid = 1'b0;
    end
    m_rlast = 1'b0;
  endtask

  task automatic slv_wr();
    bit ga, gw, hs;
    ga = 1'b0;
    gw = 1'b0;
    m_bvalid = 1'b0;
    while (!(ga && gw)) begin
      m_awready = !ga;
      m_wready  = !gw;
      pre_edge();
      if (!aresetn) begin
        ga = 1'b0;
        gw = 1'b0;
      end else begin
        if (m_awvalid & m_awready) begin
          ga = 1'b1;
          sw_aw.push_back(m_awaddr);
          sw_id = m_awid;
        end
        if (m_wvalid & m_wready) begin
          sw_w.push_back(m_wdata);
          if (m_wlast) gw = 1'b1;
        end
      end
      step();
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b1;
    m_bid     = sw_id;
    m_bresp   = {1'b0, sw_id[0]};
    hs = 1'b0;
    while (!hs) begin
      pre_edge();
      if (!aresetn) break;
      hs = m_bready;
      step();
    end
    m_bvalid = 1'b0;
  endtask

  initial forever slv_rd();
  initial forever slv_wr();

  task automatic mrd(input int n, input logic [3:0] id,
                     input logic [31:0] a, input logic [7:0] l);
    int t;
    int b;
    bit hs, ab;
    arid[n]    = id;
    araddr[n]  = a;
    arlen[n]   = l;
    arvalid[n] = 1'b1;
    rready[n]  = 1'b0;
    hs = 1'b0;
    ab = 1'b0;
    t  = 0;
    while (!hs && !ab && t < 200) begin
      pre_edge();
      if (!aresetn) ab = 1'b1;
      else if (arready[n]) begin
        hs = 1'b1;
        chk("ar_addr", m_araddr, a);
        chk("ar_id", m_arid, id);
        chk("ar_prot", m_arprot, prot_of(n));
        chk("rd_owner", rd_owner, n);
        ar_order.push_back(n);
        ar_cyc[n] = cyc;
      end
      step();
      t++;
    end
    arvalid[n] = 1'b0;
    if (!ab) chk("ar_timeout", hs, 1);
    b = 0;
    t = 0;
    while (hs && !ab && b <= int'(l) && t < 400) begin
      rready[n] = ($urandom_range(0, 3) != 0);
      pre_edge();
      if (!aresetn) ab = 1'b1;
      else begin
        chk("r_other_valid", rvalid[1-n], 0);
        if (rvalid[n] & rready[n]) begin
          chk("r_data", rdata[n], memv(a + 32'(4 * b)));
          chk("r_id", rid[n], id);
          chk("r_last", rlast[n], b == int'(l));
          b++;
          beats_seen[n] = b;
          last_cyc[n] = cyc;
        end
      end
      step();
      t++;
    end
    rready[n] = 1'b0;
    if (hs && !ab) begin
      chk("r_beats", b, int'(l) + 1);
      chk("r_idle", {m_rready, arready[0], arready[1]}, 0);
    end
  endtask

  task automatic mwr(input int n, input logic [3:0] id,
                     input logic [31:0] a, input logic [7:0] l,
                     input int lead, input int bdly);
    logic [31:0] exp_d[$];
    int t;
    bit hs;
    fork
      begin
        int ta;
        bit ha;
        repeat (lead) step();
        awid[n]    = id;
        awaddr[n]  = a;
        awlen[n]   = l;
        awvalid[n] = 1'b1;
        ha = 1'b0;
        ta = 0;
        while (!ha && ta < 300) begin
          pre_edge();
          if (awready[n]) begin
            ha = 1'b1;
            chk("aw_addr", m_awaddr, a);
            chk("aw_id", m_awid, id);
            chk("aw_prot", m_awprot, prot_of(n));
            chk("wr_owner", wr_owner, n);
          end
          step();
          ta++;
        end
        awvalid[n] = 1'b0;
        chk("aw_timeout", ha, 1);
      end
      begin
        for (int b = 0; b <= int'(l); b++) begin
          int tw;
          bit hw;
          wdata[n]  = $urandom;
          wlast[n]  = (b == int'(l));
          wvalid[n] = 1'b1;
          exp_d.push_back(wdata[n]);
          hw = 1'b0;
          tw = 0;
          while (!hw && tw < 300) begin
            pre_edge();
            hw = wready[n];
            step();
            tw++;
          end
          wvalid[n] = 1'b0;
          chk("w_timeout", hw, 1);
        end
      end
    join
    bready[n] = 1'b0;
    t = 0;
    while (!bvalid[n] && t < 100) begin
      pre_edge();
      if (!bvalid[n]) step();
      t++;
    end
    chk("b_timeout", bvalid[n], 1);
    step();
    repeat (bdly) begin
      pre_edge();
      chk("b_held", bvalid[n], 1);
      chk("aw_other_stall", awready[1-n], 0);
      step();
    end
    bready[n] = 1'b1;
    pre_edge();
    hs = bvalid[n];
    chk("b_valid", hs, 1);
    chk("b_other_valid", bvalid[1-n], 0);
    chk("b_id", bid[n], id);
    chk("b_resp", bresp[n], {1'b0, id[0]});
    step();
    bready[n] = 1'b0;
    chk("slv_aw_count", sw_aw.size(), 1);
    if (sw_aw.size() > 0) chk("slv_aw_addr", sw_aw[0], a);
    chk("slv_w_count", sw_w.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < sw_w.size(); i++)
      chk("slv_w_data", sw_w[i], exp_d[i]);
    sw_aw.delete();
    sw_w.delete();
  endtask

  initial begin
    int rn, wn;
    for (int i = 0; i < 2; i++) begin
      arid[i] = '0; araddr[i] = '0; arlen[i] = '0; arvalid[i] = 1'b0;
      rready[i] = 1'b0; awid[i] = '0; awaddr[i] = '0; awlen[i] = '0;
      awvalid[i] = 1'b0; wdata[i] = '0; wlast[i] = 1'b0;
      wvalid[i] = 1'b0; bready[i] = 1'b0;
    end
    aresetn = 1'b0;
    #1;
    chk("rst_m_valids", {m_arvalid, m_awvalid, m_wvalid}, 0);
    chk("rst_m_readys", {m_rready, m_bready}, 0);
    chk("rst_s_readys", {arready[0], arready[1], awready[0],
        awready[1], wready[0], wready[1]}, 0);
    chk("rst_s_valids", {rvalid[0], rvalid[1], bvalid[0], bvalid[1]}, 0);
    chk("rst_owners", {rd_owner, wr_owner}, 0);
    repeat (3) step();
    aresetn = 1'b1;
    step();

    // core 4-beat read alone
    mrd(0, 4'h3, 32'h1C00_0000, 8'd3);
    chk("t1_owner", rd_owner, 0);

    // simultaneous requests: JTAG first, then core after one idle cycle
    ar_order.delete();
    fork
      mrd(0, 4'h1, 32'h1C00_0040, 8'd1);
      mrd(1, 4'h2, 32'h1C00_0080, 8'd2);
    join
    chk("t2_order_n", ar_order.size(), 2);
    if (ar_order.size() == 2) begin
      chk("t2_first", ar_order[0], 1);
      chk("t2_second", ar_order[1], 0);
    end
    chk("t2_gap", ar_cyc[0] - last_cyc[1], 2);

    // JTAG write with W leading AW by two cycles
    mwr(1, 4'h6, 32'h8000_0000, 8'd0, 2, 0);

    // concurrent core read and JTAG write
    fork
      mrd(0, 4'h4, 32'h1C00_0100, 8'd3);
      mwr(1, 4'h9, 32'h8000_0010, 8'd2, 0, 1);
      begin
        repeat (4) step();
        chk("t4_owners", {rd_owner, wr_owner}, 2'b01);
      end
    join

    // reset in the middle of an 8-beat core read
    beats_seen[0] = 0;
    fork
      mrd(0, 4'h5, 32'h1C00_0200, 8'd7);
      begin
        int tr;
        tr = 0;
        while (beats_seen[0] < 3 && tr < 300) begin
          step();
          tr++;
        end
        chk("t5_reach_beat3", beats_seen[0] >= 3, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_s_valids", {rvalid[0], rvalid[1], bvalid[0],
            bvalid[1]}, 0);
        chk("t5_m_valids", {m_arvalid, m_awvalid, m_wvalid,
            m_rready, m_bready}, 0);
        chk("t5_owners", {rd_owner, wr_owner}, 0);
        step();
        step();
        aresetn = 1'b1;
      end
    join
    chk("t5_beats_before_rst", beats_seen[0], 3);
    step();
    mrd(0, 4'h7, 32'h1C00_0300, 8'd1);

    // B held by JTAG while core write waits
    fork
      mwr(1, 4'hA, 32'h8000_0100, 8'd0, 0, 5);
      begin
        step();
        mwr(0, 4'hB, 32'h1C00_0400, 8'd1, 0, 0);
      end
    join

    // randomized concurrent traffic
    for (int i = 0; i < 16; i++) begin
      rn = $urandom_range(0, 1);
      wn = $urandom_range(0, 1);
      fork
        mrd(rn, 4'($urandom), {$urandom_range(0, 255), 2'b00},
            8'($urandom_range(0, 7)));
        mwr(wn, 4'($urandom), {$urandom_range(0, 255), 2'b00},
            8'($urandom_range(0, 7)), $urandom_range(0, 3),
            $urandom_range(0, 2));
      join
      chk("rnd_owners", {rd_owner, wr_owner}, {1'(rn), 1'(wn)});
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
